ex_stage_md: RTL and testbench
==============================

// Module: ex_stage_md
// PURPOSE
//  Parametrised registered execute stage for the 5-stage core; sits between ID/EX and EX/MEM.
//  Performs the logic/shift ops in one cycle, plus MULT/MULTU (1 cycle) and DIV/DIVU (iterative, WIDTH cycles).
//  Holds the HI/LO register pair internally; MFHI/MFLO/MTHI/MTLO complete here.
//  Raises stall_o while a divide is in progress and supports a synchronous flush.
// PARAMETERS
//  WIDTH       32  datapath width; must be a power of two >= 8
//  REG_ADDR_W   5  destination register address width
// PORTS
//  clk        in   1           rising-edge clock (the only clock)
//  rst_n      in   1           asynchronous, active-low reset
//  flush_i    in   1           synchronous cancel of current/accepted op
//  valid_i    in   1           instruction present on *_i this cycle
//  aluop_i    in   8           operation code (table below)
//  reg1_i     in   WIDTH       operand 1 (shift amount for shifts, dividend, MTHI/MTLO source)
//  reg2_i     in   WIDTH       operand 2 (shifted value, divisor)
//  wd_i       in   REG_ADDR_W  destination GPR
//  wreg_i     in   1           GPR write enable from decode
//  stall_o    out  1           =1 while state==BUSY; upstream holds *_i stable
//  valid_o    out  1           registered; result in wdata_o/wd_o/wreg_o is valid
//  wdata_o    out  WIDTH       registered result
//  wd_o       out  REG_ADDR_W  registered destination
//  wreg_o     out  1           registered GPR write enable
// BEHAVIOUR
//  Opcodes: 24 AND, 25 OR, 26 XOR, 27 NOR, 7C SLL, 02 SRL, 03 SRA, 10 MFHI, 11 MTHI, 12 MFLO,
//   13 MTLO, 18 MULT, 19 MULTU, 1A DIV, 1B DIVU (hex). Other codes: wdata_o=0, wreg_o=0, valid_o still 1.
//  Reset (rst_n=0, async): state=IDLE, HI=LO=0, counter=0, valid_o=0, wdata_o=0, wd_o=0, wreg_o=0, stall_o=0.
//  Accept: rising edge with valid_i=1, stall_o=0, flush_i=0. stall_o depends on state only (no comb. path from *_i).
//  Single-cycle ops: result registered at accept edge; valid_o=1 for one cycle; wd_o=wd_i, wreg_o=wreg_i.
//  Shifts: amount = reg1_i[$clog2(WIDTH)-1:0]; SLL/SRL zero-fill; SRA replicates reg2_i[WIDTH-1]; amount 0 = pass.
//  MULT/MULTU: 2*WIDTH product of reg1_i*reg2_i (signed/unsigned); {HI,LO}<=product at accept edge;
//   wreg_o=0, valid_o=1 next cycle.
//  MTHI/MTLO: HI or LO <= reg1_i at accept edge; wreg_o=0. MFHI/MFLO: wdata_o<=HI/LO.
//  An MF* accepted the cycle after a MULT/MT*/DIV completion reads the updated value (HI/LO written at that edge).
//  Divide FSM: IDLE -> BUSY at accept of DIV/DIVU; latches |operands| (DIV) plus result signs; counter=WIDTH.
//   BUSY: one restoring-division step per cycle, counter decrements; valid_i ignored.
//   BUSY -> IDLE on the edge where counter reaches 0; at that edge LO<=quotient, HI<=remainder,
//   valid_o<=1, wreg_o<=0. Total: accept edge + WIDTH edges; stall_o high for exactly WIDTH cycles.
//  Signed DIV: quotient negated if operand signs differ; remainder takes dividend sign.
//  Divide by zero: skip iteration; next edge LO<={WIDTH{1'b1}}, HI<=dividend, valid_o=1, stall_o low after 1 cycle.
//  DIV of most-negative by -1: LO=most-negative, HI=0 (natural wrap, no trap).
//  flush_i=1 (priority over valid_i, any state): next edge state=IDLE, counter=0, valid_o=0, wreg_o=0,
//   wdata_o=0; HI/LO keep pre-divide values (partial result discarded).
//  valid_o=0 on every edge where nothing completes; wdata_o/wd_o then hold last value but wreg_o=0.
//  Reset mid-divide: immediate return to reset values; no HI/LO update.
// TESTING
//  1 ORI-style: aluop=25, reg1=0000_F0F0, reg2=0F0F_0000 -> next cycle valid_o=1, wdata_o=0F0F_F0F0.
//  2 SRA: aluop=03, reg1=4, reg2=8000_0010 -> wdata_o=F800_0001; amount 0 -> 8000_0010 unchanged.
//  3 MULT FFFF_FFFE * 0000_0003 then MFHI,MFLO back-to-back -> FFFF_FFFF then FFFF_FFFA.
//  4 DIV reg1=-7, reg2=2 -> stall_o high 32 cycles, then LO=FFFF_FFFD, HI=FFFF_FFFF; next-op held.
//  5 DIVU by 0 with reg1=1234 -> LO=FFFF_FFFF, HI=1234 after 1 stall cycle.
//  6 flush_i at BUSY cycle 10 and rst_n low at BUSY cycle 5 -> IDLE, valid_o=0, HI/LO unchanged (0 after reset).

Source files
------------

// File: rtl/ex_stage_md.sv
// ex_stage_md -- registered execute stage of the 5-stage core.
//
// Purpose:
//   One-cycle logic/shift ops, one-cycle MULT/MULTU into HI/LO, iterative
//   restoring DIV/DIVU (WIDTH steps) into HI/LO, and MFHI/MFLO/MTHI/MTLO.
//   Holds HI/LO internally. stall_o is high while a divide iterates.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush_i         synchronous cancel of the current/accepted op
//   valid_i         instruction present on the *_i inputs
//   aluop_i         8-bit operation code
//   reg1_i, reg2_i  operands (reg1 = shift amount / dividend / MT* source)
//   wd_i, wreg_i    destination GPR and its write enable
//   stall_o         high while the divider is busy
//   valid_o         registered: a result completed on the last edge
//   wdata_o, wd_o, wreg_o  registered result, destination, write enable
//
// Handshake: an op is accepted on a rising edge where valid_i=1, stall_o=0
// and flush_i=0. While stall_o=1 valid_i is ignored and upstream holds its
// inputs. valid_o pulses for one cycle per completed op.
module ex_stage_md #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  valid_i,
  input  logic [7:0]            aluop_i,
  input  logic [WIDTH-1:0]      reg1_i,
  input  logic [WIDTH-1:0]      reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  output logic                  stall_o,
  output logic                  valid_o,
  output logic [WIDTH-1:0]      wdata_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [7:0] OP_AND = 8'h24, OP_OR = 8'h25, OP_XOR = 8'h26, OP_NOR = 8'h27;
  localparam logic [7:0] OP_SLL = 8'h7C, OP_SRL = 8'h02, OP_SRA = 8'h03;
  localparam logic [7:0] OP_MFHI = 8'h10, OP_MTHI = 8'h11, OP_MFLO = 8'h12, OP_MTLO = 8'h13;
  localparam logic [7:0] OP_MULT = 8'h18, OP_MULTU = 8'h19, OP_DIV = 8'h1A, OP_DIVU = 8'h1B;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]      hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]      rem_q, rem_d;   // partial remainder
  logic [WIDTH-1:0]      quo_q, quo_d;   // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0]      dvs_q, dvs_d;   // |divisor|
  logic                  negq_q, negq_d; // negate quotient at the end
  logic                  negr_q, negr_d; // negate remainder at the end
  logic                  dz_q, dz_d;     // divide by zero: quo_q holds the raw dividend
  logic                  valid_q, valid_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic [REG_ADDR_W-1:0] wd_q, wd_d;
  logic                  wreg_q, wreg_d;

  logic                  accept;
  logic [SHW-1:0]        shamt;
  logic [2*WIDTH-1:0]    prod_s, prod_u;
  logic [WIDTH-1:0]      abs1, abs2;
  logic [WIDTH:0]        trial;
  logic                  ge;
  logic [WIDTH-1:0]      rem_step, quo_step;

  assign stall_o = (state_q == BUSY);
  assign accept  = valid_i & ~stall_o & ~flush_i;
  assign shamt   = reg1_i[SHW-1:0];

  assign prod_s = {{WIDTH{reg1_i[WIDTH-1]}}, reg1_i} * {{WIDTH{reg2_i[WIDTH-1]}}, reg2_i};
  assign prod_u = {{WIDTH{1'b0}}, reg1_i} * {{WIDTH{1'b0}}, reg2_i};
  assign abs1   = reg1_i[WIDTH-1] ? -reg1_i : reg1_i;
  assign abs2   = reg2_i[WIDTH-1] ? -reg2_i : reg2_i;

  // One restoring step: bring the next dividend bit into the remainder and
  // subtract the divisor; the borrow (MSB of the WIDTH+1 result) says whether
  // the subtraction fits.
  assign trial    = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
  assign ge       = ~trial[WIDTH];
  assign rem_step = ge ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
  assign quo_step = {quo_q[WIDTH-2:0], ge};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    valid_d = 1'b0;
    wdata_d = wdata_q;
    wd_d    = wd_q;
    wreg_d  = 1'b0;

    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      wdata_d = '0;
    end else if (state_q == BUSY) begin
      if (dz_q) begin
        state_d = IDLE;
        cnt_d   = '0;
        lo_d    = '1;
        hi_d    = quo_q;
        valid_d = 1'b1;
      end else begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          lo_d    = negq_q ? -quo_step : quo_step;
          hi_d    = negr_q ? -rem_step : rem_step;
          valid_d = 1'b1;
        end
      end
    end else if (accept) begin
      valid_d = 1'b1;
      wd_d    = wd_i;
      wreg_d  = wreg_i;
      wdata_d = '0;
      case (aluop_i)
        OP_AND:  wdata_d = reg1_i & reg2_i;
        OP_OR:   wdata_d = reg1_i | reg2_i;
        OP_XOR:  wdata_d = reg1_i ^ reg2_i;
        OP_NOR:  wdata_d = ~(reg1_i | reg2_i);
        OP_SLL:  wdata_d = reg2_i << shamt;
        OP_SRL:  wdata_d = reg2_i >> shamt;
        OP_SRA:  wdata_d = $unsigned($signed(reg2_i) >>> shamt);
        OP_MFHI: wdata_d = hi_q;
        OP_MFLO: wdata_d = lo_q;
        OP_MTHI: begin
          hi_d   = reg1_i;
          wreg_d = 1'b0;
        end
        OP_MTLO: begin
          lo_d   = reg1_i;
          wreg_d = 1'b0;
        end
        OP_MULT: begin
          {hi_d, lo_d} = prod_s;
          wreg_d       = 1'b0;
        end
        OP_MULTU: begin
          {hi_d, lo_d} = prod_u;
          wreg_d       = 1'b0;
        end
        OP_DIV, OP_DIVU: begin
          // Nothing completes on this edge; the result appears when the
          // iteration finishes.
          valid_d = 1'b0;
          wreg_d  = 1'b0;
          wdata_d = wdata_q;
          wd_d    = wd_q;
          state_d = BUSY;
          dz_d    = (reg2_i == '0);
          cnt_d   = (reg2_i == '0) ? CNT_ONE : CNT_FULL;
          rem_d   = '0;
          if (aluop_i == OP_DIV) begin
            quo_d  = (reg2_i == '0) ? reg1_i : abs1;
            dvs_d  = abs2;
            negq_d = reg1_i[WIDTH-1] ^ reg2_i[WIDTH-1];
            negr_d = reg1_i[WIDTH-1];
          end else begin
            quo_d  = reg1_i;
            dvs_d  = reg2_i;
            negq_d = 1'b0;
            negr_d = 1'b0;
          end
        end
        default: wreg_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      valid_q <= 1'b0;
      wdata_q <= '0;
      wd_q    <= '0;
      wreg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      valid_q <= valid_d;
      wdata_q <= wdata_d;
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
    end
  end

  assign valid_o = valid_q;
  assign wdata_o = wdata_q;
  assign wd_o    = wd_q;
  assign wreg_o  = wreg_q;

endmodule

// File: tb/tb_ex_stage_md.sv
// tb_ex_stage_md -- self-checking bench for ex_stage_md (WIDTH=32).
// Directed cases followed by randomized ops, compared against an
// arithmetic reference model of the register file HI/LO and results.
module tb_ex_stage_md;

  localparam int W  = 32;
  localparam int AW = 5;

  localparam logic [7:0] OP_AND = 8'h24, OP_OR = 8'h25, OP_XOR = 8'h26, OP_NOR = 8'h27;
  localparam logic [7:0] OP_SLL = 8'h7C, OP_SRL = 8'h02, OP_SRA = 8'h03;
  localparam logic [7:0] OP_MFHI = 8'h10, OP_MTHI = 8'h11, OP_MFLO = 8'h12, OP_MTLO = 8'h13;
  localparam logic [7:0] OP_MULT = 8'h18, OP_MULTU = 8'h19, OP_DIV = 8'h1A, OP_DIVU = 8'h1B;

  logic          clk, rst_n, flush_i, valid_i, wreg_i;
  logic [7:0]    aluop_i;
  logic [W-1:0]  reg1_i, reg2_i;
  logic [AW-1:0] wd_i;
  logic          stall_o, valid_o, wreg_o;
  logic [W-1:0]  wdata_o;
  logic [AW-1:0] wd_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] hi_m, lo_m;

  ex_stage_md #(.WIDTH(W), .REG_ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid_i),
    .aluop_i(aluop_i), .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i),
    .wreg_i(wreg_i), .stall_o(stall_o), .valid_o(valid_o),
    .wdata_o(wdata_o), .wd_o(wd_o), .wreg_o(wreg_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: applies an op to hi_m/lo_m, returns expected write
  // enable, whether wdata is defined, and the expected data.
  task automatic model_op(input logic [7:0] op, input logic [W-1:0] r1, input logic [W-1:0] r2,
                          input logic wreg, output logic ewreg, output logic has_data,
                          output logic [W-1:0] edata);
    longint p;
    int a, b;
    ewreg    = wreg;
    has_data = 1'b1;
    edata    = '0;
    case (op)
      OP_AND:  edata = r1 & r2;
      OP_OR:   edata = r1 | r2;
      OP_XOR:  edata = r1 ^ r2;
      OP_NOR:  edata = ~(r1 | r2);
      OP_SLL:  edata = r2 << r1[4:0];
      OP_SRL:  edata = r2 >> r1[4:0];
      OP_SRA:  begin a = r2; edata = a >>> r1[4:0]; end
      OP_MFHI: edata = hi_m;
      OP_MFLO: edata = lo_m;
      OP_MTHI: begin hi_m = r1; ewreg = 0; has_data = 0; end
      OP_MTLO: begin lo_m = r1; ewreg = 0; has_data = 0; end
      OP_MULT: begin
        a = r1; b = r2;
        p = longint'(a) * longint'(b);
        {hi_m, lo_m} = p;
        ewreg = 0; has_data = 0;
      end
      OP_MULTU: begin
        p = longint'({32'h0, r1}) * longint'({32'h0, r2});
        {hi_m, lo_m} = p;
        ewreg = 0; has_data = 0;
      end
      OP_DIV, OP_DIVU: begin
        ewreg = 0; has_data = 0;
        if (r2 == 0) begin
          lo_m = '1; hi_m = r1;
        end else if (op == OP_DIVU) begin
          lo_m = r1 / r2; hi_m = r1 % r2;
        end else if (r1 == 32'h8000_0000 && r2 == 32'hFFFF_FFFF) begin
          lo_m = 32'h8000_0000; hi_m = 0;
        end else begin
          a = r1; b = r2;
          lo_m = a / b; hi_m = a % b;
        end
      end
      default: ewreg = 0;
    endcase
  endtask

  // driver: issue one op, then check its completion
  task automatic run_op(input logic [7:0] op, input logic [W-1:0] r1, input logic [W-1:0] r2,
                        input logic [AW-1:0] wd, input logic wreg, input string tag);
    logic ewreg, has_data, bad_valid;
    logic [W-1:0] edata;
    int cycles, exp_cycles;
    exp_cycles = (r2 == 0) ? 1 : W;
    @(negedge clk);
    valid_i = 1'b1; aluop_i = op; reg1_i = r1; reg2_i = r2; wd_i = wd; wreg_i = wreg;
    model_op(op, r1, r2, wreg, ewreg, has_data, edata);
    if (has_data) exp_q.push_back(edata);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    if (op == OP_DIV || op == OP_DIVU) begin
      check({tag, "_stall_start"}, stall_o, 1);
      check({tag, "_valid_start"}, valid_o, 0);
      cycles = 0;
      bad_valid = 0;
      while (cycles < 100) begin
        @(negedge clk);
        // A competing op presented while busy must be ignored.
        valid_i = 1'b1; aluop_i = OP_MTHI; reg1_i = $urandom; reg2_i = $urandom;
        @(posedge clk);
        #1;
        cycles++;
        if (stall_o && valid_o) bad_valid = 1;
        if (!stall_o) break;
      end
      valid_i = 1'b0;
      check({tag, "_stall_cycles"}, cycles, exp_cycles);
      check({tag, "_valid_busy"}, bad_valid, 0);
      check({tag, "_valid_done"}, valid_o, 1);
      check({tag, "_wreg_done"}, wreg_o, 0);
    end else begin
      check({tag, "_valid"}, valid_o, 1);
      check({tag, "_wreg"}, wreg_o, ewreg);
      check({tag, "_wd"}, wd_o, wd);
      if (has_data) begin
        if (exp_q.size() > 0) check({tag, "_wdata"}, wdata_o, exp_q.pop_front());
      end
    end
  endtask

  task automatic start_div_raw(input logic [W-1:0] r1, input logic [W-1:0] r2);
    @(negedge clk);
    valid_i = 1'b1; aluop_i = OP_DIV; reg1_i = r1; reg2_i = r2; wd_i = 0; wreg_i = 1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  initial begin
    logic [7:0] ops[16];
    logic [7:0] op;
    logic [W-1:0] r1, r2;
    ops = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA, OP_MFHI,
            OP_MTHI, OP_MFLO, OP_MTLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, 8'h55};
    hi_m = 0; lo_m = 0;
    rst_n = 1'b0; flush_i = 1'b0; valid_i = 1'b0; aluop_i = 0;
    reg1_i = 0; reg2_i = 0; wd_i = 0; wreg_i = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", stall_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_wdata", wdata_o, 0);
    check("rst_wd", wd_o, 0);
    check("rst_wreg", wreg_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(OP_MFHI, 0, 0, 5'd1, 1, "rst_hi");
    run_op(OP_OR, 32'h0000_F0F0, 32'h0F0F_0000, 5'd3, 1, "ori");
    run_op(OP_SRA, 32'd4, 32'h8000_0010, 5'd4, 1, "sra4");
    run_op(OP_SRA, 32'd0, 32'h8000_0010, 5'd4, 1, "sra0");
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 5'd0, 0, "mult");
    run_op(OP_MFHI, 0, 0, 5'd6, 1, "mult_hi");
    run_op(OP_MFLO, 0, 0, 5'd7, 1, "mult_lo");
    run_op(OP_DIV, -32'sd7, 32'd2, 5'd0, 0, "div_neg");
    run_op(OP_MFLO, 0, 0, 5'd8, 1, "div_lo");
    run_op(OP_MFHI, 0, 0, 5'd9, 1, "div_hi");
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 0, "div_min");
    run_op(OP_MFLO, 0, 0, 5'd8, 1, "divmin_lo");
    run_op(OP_MFHI, 0, 0, 5'd9, 1, "divmin_hi");
    run_op(OP_DIVU, 32'd1234, 32'd0, 5'd0, 0, "divz");
    run_op(OP_MFLO, 0, 0, 5'd10, 1, "divz_lo");
    run_op(OP_MFHI, 0, 0, 5'd11, 1, "divz_hi");

    // flush at the tenth busy cycle: partial result discarded
    start_div_raw(32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    check("flush_stall", stall_o, 0);
    check("flush_valid", valid_o, 0);
    check("flush_wreg", wreg_o, 0);
    check("flush_wdata", wdata_o, 0);
    run_op(OP_MFLO, 0, 0, 5'd12, 1, "flush_lo");
    run_op(OP_MFHI, 0, 0, 5'd13, 1, "flush_hi");

    // reset mid-divide
    start_div_raw(32'd999, 32'd5);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_stall", stall_o, 0);
    check("mrst_valid", valid_o, 0);
    check("mrst_wdata", wdata_o, 0);
    check("mrst_wreg", wreg_o, 0);
    hi_m = 0; lo_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(OP_MFLO, 0, 0, 5'd14, 1, "mrst_lo");
    run_op(OP_MFHI, 0, 0, 5'd15, 1, "mrst_hi");

    // randomized ops
    for (int i = 0; i < 80; i++) begin
      op = ops[$urandom_range(0, 15)];
      r1 = $urandom;
      r2 = $urandom;
      if (op == OP_DIV || op == OP_DIVU) begin
        case ($urandom_range(0, 7))
          0: r2 = 0;
          1: begin r1 = 32'h8000_0000; r2 = 32'hFFFF_FFFF; end
          2: r2 = $urandom_range(1, 20);
          default: ;
        endcase
      end
      run_op(op, r1, r2, AW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), "rand");
      if ($urandom_range(0, 3) == 0)
        run_op(($urandom_range(0, 1) == 1) ? OP_MFHI : OP_MFLO, 0, 0, 5'd1, 1, "rand_mf");
    end
    run_op(OP_MFHI, 0, 0, 5'd2, 1, "final_hi");
    run_op(OP_MFLO, 0, 0, 5'd3, 1, "final_lo");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
